pri_grant_arb: RTL and testbench
================================

# pri_grant_arb

Sequential grant stage directly downstream of the combinational priority selector. It takes the selector's max-priority value and its tie vector (every requester at that priority), and breaks ties round-robin. It issues a registered one-hot grant, holds it until the owner releases it or a hold timeout expires, then re-arbitrates. One grant is outstanding at a time.

## Interface
- N, 4: number of requesters; must match the upstream selector.
- P, 16: priority levels; priority width PW = $clog2(P).
- TIMEOUT, 255: maximum grant hold in cycles; 0 disables the timeout.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_in  input  N  tie vector from the selector; bit i = requester i holds the current max priority.
- pri_in  input  PW  max priority from the selector; 0 = no valid request.
- done  input  N  per-requester release; only the bit of the current owner is honoured.
- gnt  output  N  one-hot grant, registered.
- gnt_valid  output  1  equals |gnt.
- gnt_id  output  $clog2(N)  binary index of the owner; 0 when idle.
- gnt_pri  output  PW  pri_in captured at grant time; 0 when idle.
- busy  output  1  state is HOLD.
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, gnt_pri=0, busy=0, timeout_err=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- State IDLE:
  - Eligible when pri_in!=0 and req_in!=0. Both must hold; req_in!=0 with pri_in==0 is ignored.
  - If eligible, pick the first set bit of req_in scanning upward from rr_ptr, wrapping modulo N.
  - Register gnt/gnt_id/gnt_pri, set rr_ptr = (winner+1) mod N, clear hold_cnt, go to HOLD.
- State HOLD:
  - gnt, gnt_id and gnt_pri stay frozen. Changes on req_in and pri_in are ignored.
  - done[gnt_id]=1: clear all grant outputs and go to IDLE. timeout_err stays 0.
  - done bits of non-owners are ignored in every state. Any done bit in IDLE is ignored.
  - Otherwise, when TIMEOUT!=0, hold_cnt increments. When hold_cnt reaches TIMEOUT-1 without done, clear the grant outputs, pulse timeout_err for one cycle and go to IDLE. rr_ptr is not changed again; it already points past the revoked owner.
  - done[gnt_id] and timeout expiry in the same cycle: done wins, no timeout_err.
- hold_cnt width is $clog2(TIMEOUT+1). It never wraps because it is cleared on every HOLD entry. With TIMEOUT=0 the counter is held at 0.
- Wrap-around: rr_ptr=N-1 with the winner at N-1 gives rr_ptr=0.
- Asynchronous reset mid-HOLD forces every reset value immediately, independent of clk.
- The block is purely registered. Arbitration logic is combinational from req_in, pri_in and rr_ptr, sampled at the edge.

## Timing
- Grant latency: 1 cycle. A request sampled at edge k gives gnt high after edge k.
- Release latency: 1 cycle. done sampled at edge m gives gnt low after edge m.
- Minimum dead time between grants is 1 cycle, because IDLE samples at edge m+1. Back-to-back grants repeat every hold+1 cycles.
- With a timeout, gnt is high for exactly TIMEOUT cycles. timeout_err is high in the first cycle after gnt falls.
- busy == gnt_valid in every cycle.

## Test plan
- Reset: assert rst_n=0 mid-cycle with req_in=1111, pri_in=7 → all outputs 0 asynchronously. After release, the first grant is gnt=0001 (rr_ptr=0).
- Single request: req_in=0100, pri_in=5 at edge 1 → gnt=0100, gnt_id=2, gnt_pri=5, busy=1 after edge 1. done=0100 at edge 4 → gnt=0 after edge 4. Changing pri_in to 9 during HOLD leaves gnt_pri=5.
- Round-robin tie: req_in=1111, pri_in=3 held, done pulsed for the owner one cycle after each grant → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one idle cycle between grants.
- Timeout: TIMEOUT=8, req_in=0010, pri_in=2, done never asserted → gnt high exactly 8 cycles, timeout_err one-cycle pulse. With req_in still 0010, re-grant to 0010 on the next cycle.
- Foreign and coincident done: owner 2, done=0001 → ignored, grant held. With TIMEOUT=4, assert done=0100 in the 4th hold cycle → release with timeout_err=0.
- Zero priority: req_in=1000, pri_in=0 for 10 cycles → no grant, busy=0.

Source files
------------

// File: rtl/pri_grant_arb_if.sv
// Bundle between the priority selector and the grant stage.
// The grant stage uses the slave modport; the selector side uses master.
interface pri_grant_arb_if #(
    parameter int N = 4,
    parameter int P = 16
);
    localparam int PW = $clog2(P);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req_in;
    logic [PW-1:0] pri_in;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic [PW-1:0] gnt_pri;
    logic          busy;
    logic          timeout_err;

    modport master (
        output req_in, pri_in, done,
        input  gnt, gnt_valid, gnt_id, gnt_pri, busy, timeout_err
    );

    modport slave (
        input  req_in, pri_in, done,
        output gnt, gnt_valid, gnt_id, gnt_pri, busy, timeout_err
    );
endinterface

// File: rtl/pri_grant_arb.sv
// Registered round-robin tie breaker behind the priority selector:
// one grant at a time, held until owner release or hold timeout.
module pri_grant_arb #(
    parameter int N       = 4,
    parameter int P       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    pri_grant_arb_if.slave     bus
);
    localparam int PW = $clog2(P);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [PW-1:0] gnt_pri_q, gnt_pri_d;
    logic          timeout_err_q, timeout_err_d;

    logic          pick_found_s;
    logic [IW-1:0] pick_id_s;
    logic          eligible_s;

    // Round-robin search: first requester at or above rr_ptr, wrapping
    always_comb begin
        logic [IW-1:0] idx_v;
        pick_found_s = 1'b0;
        pick_id_s    = {IW{1'b0}};
        idx_v        = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx_v = IW'((int'(rr_ptr_q) + i) % N);
            if (!pick_found_s && bus.req_in[idx_v]) begin
                pick_found_s = 1'b1;
                pick_id_s    = idx_v;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        eligible_s = (bus.pri_in != {PW{1'b0}}) && pick_found_s;
    end

    // Next-state logic for grant capture, release and timeout revocation
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        gnt_pri_d     = gnt_pri_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (eligible_s) begin
                    state_d    = HOLD;
                    gnt_d      = {{(N-1){1'b0}}, 1'b1} << pick_id_s;
                    gnt_id_d   = pick_id_s;
                    gnt_pri_d  = bus.pri_in;
                    rr_ptr_d   = (pick_id_s == IW'(N - 1)) ? {IW{1'b0}} : pick_id_s + IW'(1);
                    hold_cnt_d = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // Owner release takes precedence over a coincident expiry
                if (bus.done[gnt_id_q]) begin
                    state_d    = IDLE;
                    gnt_d      = {N{1'b0}};
                    gnt_id_d   = {IW{1'b0}};
                    gnt_pri_d  = {PW{1'b0}};
                    hold_cnt_d = {CW{1'b0}};
                end else if ((TIMEOUT != 0) && (hold_cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d       = IDLE;
                    gnt_d         = {N{1'b0}};
                    gnt_id_d      = {IW{1'b0}};
                    gnt_pri_d     = {PW{1'b0}};
                    hold_cnt_d    = {CW{1'b0}};
                    timeout_err_d = 1'b1;
                end else if (TIMEOUT != 0) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end else begin
                    hold_cnt_d = {CW{1'b0}};
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = {N{1'b0}};
                gnt_id_d   = {IW{1'b0}};
                gnt_pri_d  = {PW{1'b0}};
                hold_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= {IW{1'b0}};
            hold_cnt_q    <= {CW{1'b0}};
            gnt_q         <= {N{1'b0}};
            gnt_id_q      <= {IW{1'b0}};
            gnt_pri_q     <= {PW{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            gnt_pri_q     <= gnt_pri_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_valid   = |gnt_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.gnt_pri     = gnt_pri_q;
    assign bus.busy        = (state_q == HOLD);
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_pri_grant_arb.sv
// Bench for pri_grant_arb: two instances (TIMEOUT 8 and 4) share stimulus
// and are compared every cycle against a cycle-count reference model.
module tb_pri_grant_arb;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    pri_grant_arb_if #(.N(4), .P(16)) bus8 ();
    pri_grant_arb_if #(.N(4), .P(16)) bus4 ();

    pri_grant_arb #(.N(4), .P(16), .TIMEOUT(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    pri_grant_arb #(.N(4), .P(16), .TIMEOUT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 idle), cycles the grant has been high
    int       to_lim [2] = '{8, 4};
    int       m_owner[2];
    int       m_ptr  [2];
    int       m_held [2];
    int       m_pri  [2];
    bit       m_tout [2];
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_ptr[d] = 0; m_held[d] = 0; m_pri[d] = 0; m_tout[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r, input logic [3:0] p, input logic [3:0] dn);
        if (m_owner[d] < 0) begin
            m_tout[d] = 1'b0;
            if (p != 4'd0 && r != 4'd0) begin
                for (int i = 0; i < 4; i++) begin
                    int c;
                    c = (m_ptr[d] + i) % 4;
                    if (r[c] && m_owner[d] < 0) m_owner[d] = c;
                end
                m_pri[d]  = int'(p);
                m_ptr[d]  = (m_owner[d] + 1) % 4;
                m_held[d] = 1;
            end
        end else if (dn[m_owner[d]]) begin
            m_owner[d] = -1; m_tout[d] = 1'b0;
        end else if (m_held[d] == to_lim[d]) begin
            m_owner[d] = -1; m_tout[d] = 1'b1;
        end else begin
            m_held[d]++; m_tout[d] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [3:0] g, pr; logic [1:0] id; logic v, b, te;
            bit act;
            g  = (d == 0) ? bus8.gnt         : bus4.gnt;
            id = (d == 0) ? bus8.gnt_id      : bus4.gnt_id;
            pr = (d == 0) ? bus8.gnt_pri     : bus4.gnt_pri;
            v  = (d == 0) ? bus8.gnt_valid   : bus4.gnt_valid;
            b  = (d == 0) ? bus8.busy        : bus4.busy;
            te = (d == 0) ? bus8.timeout_err : bus4.timeout_err;
            act = (m_owner[d] >= 0);
            chk($sformatf("gnt[%0d]", d),       32'(g),  act ? 32'(1 << m_owner[d]) : 32'd0);
            chk($sformatf("gnt_id[%0d]", d),    32'(id), act ? 32'(m_owner[d]) : 32'd0);
            chk($sformatf("gnt_pri[%0d]", d),   32'(pr), act ? 32'(m_pri[d]) : 32'd0);
            chk($sformatf("gnt_valid[%0d]", d), 32'(v),  32'(act));
            chk($sformatf("busy[%0d]", d),      32'(b),  32'(act));
            chk($sformatf("timeout_err[%0d]", d), 32'(te), 32'(m_tout[d]));
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] p, input logic [3:0] dn);
        bus8.req_in = r; bus8.pri_in = p; bus8.done = dn;
        bus4.req_in = r; bus4.pri_in = p; bus4.done = dn;
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) model_step(d, bus8.req_in, bus8.pri_in, bus8.done);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        model_reset();
        set_in(4'b1111, 4'd7, 4'b0000);
        #12;
        check_all();
        rst_n = 1'b1;

        // First grant after reset starts at requester 0, then reset mid-HOLD
        step();
        chk("first_gnt", 32'(bus8.gnt), 32'h1);
        step();
        do_reset();

        // Single request, priority frozen during hold
        set_in(4'b0100, 4'd5, 4'b0000);
        step();
        chk("single_id", 32'(bus8.gnt_id), 32'd2);
        step();
        set_in(4'b1111, 4'd9, 4'b0000);
        step();
        chk("pri_frozen", 32'(bus8.gnt_pri), 32'd5);
        set_in(4'b1111, 4'd9, 4'b0100);
        step();
        chk("single_release", 32'(bus8.gnt), 32'd0);
        set_in(4'b0000, 4'd0, 4'b0000);
        step();
        do_reset();

        // Round-robin among four tied requesters, one idle cycle between grants
        set_in(4'b1111, 4'd3, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rr_gnt%0d", k), 32'(bus8.gnt), 32'(exp_seq[k]));
            set_in(4'b1111, 4'd3, exp_seq[k]);
            step();
            chk($sformatf("rr_idle%0d", k), 32'(bus8.gnt), 32'd0);
            set_in(4'b1111, 4'd3, 4'b0000);
        end
        do_reset();

        // Timeout: grant held exactly TIMEOUT cycles, then pulse and re-grant
        set_in(4'b0010, 4'd2, 4'b0000);
        step();
        n = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus8.gnt_valid) n++;
            else break;
        end
        chk("tout_len", 32'(n), 32'd8);
        chk("tout_pulse", 32'(bus8.timeout_err), 32'd1);
        step();
        chk("tout_regrant", 32'(bus8.gnt), 32'h2);
        chk("tout_pulse_end", 32'(bus8.timeout_err), 32'd0);
        do_reset();

        // Foreign done ignored; owner done coincident with expiry wins
        set_in(4'b0100, 4'd6, 4'b0000);
        step();
        set_in(4'b0100, 4'd6, 4'b0001);
        step();
        chk("foreign_done", 32'(bus4.gnt), 32'h4);
        set_in(4'b0100, 4'd6, 4'b0000);
        step();
        step();
        set_in(4'b0000, 4'd0, 4'b0100);
        step();
        chk("coinc_gnt", 32'(bus4.gnt), 32'd0);
        chk("coinc_terr", 32'(bus4.timeout_err), 32'd0);
        set_in(4'b0000, 4'd0, 4'b0000);
        step();

        // Zero priority never grants
        set_in(4'b1000, 4'd0, 4'b0000);
        for (int c = 0; c < 10; c++) step();
        chk("zero_pri_busy", 32'(bus8.busy), 32'd0);

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [3:0] r, p, dn;
            r  = 4'($urandom_range(0, 15));
            p  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            dn = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            set_in(r, p, dn);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
